chdr_conv_sched: RTL
====================

CHDR_CONV_SCHED -- requirements
Module: chdr_conv_sched

Interface
Parameters:
REQ-001 The block SHALL have parameter BASE, default 0, giving the settings-bus address of the control register.
REQ-002 The block SHALL have parameter NUM_PORTS, default 4, range 2..8, giving the number of CHDR input streams sharing one converter.

Ports (N = NUM_PORTS, P = max(1, clog2(N))):
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock.
REQ-004 The block SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-005 The block SHALL have ports set_stb (input, 1 bit), set_addr (input, 8 bits) and set_data (input, 32 bits): the settings bus.
REQ-006 The block SHALL have ports i_tdata (input, 64*N bits), i_tlast (input, N bits), i_tvalid (input, N bits) and i_tready (output, N bits): the per-port CHDR inputs, with port k occupying bits [64k+63:64k].
REQ-007 The block SHALL have ports o_tdata (output, 64 bits), o_tlast (output, 1 bit), o_tvalid (output, 1 bit) and o_tready (input, 1 bit): the stream to the shared converter.
REQ-008 The block SHALL have port o_port, output, P bits: index of the input port currently granted, valid whenever o_tvalid = 1.
REQ-009 The block SHALL have port stat_cnt, output, 16*N bits: per-port completed-packet counters (see Configuration).

Function
REQ-010 The block SHALL arbitrate at packet granularity; once a port is granted, the whole packet through tlast SHALL pass before any other port is granted.
REQ-011 The state machine SHALL have two states, IDLE and PASS.
REQ-012 In IDLE, the block SHALL drive o_tvalid = 0 and i_tready = 0 on all ports.
REQ-013 In IDLE, the block SHALL scan enabled ports with i_tvalid = 1 round-robin, starting at (last_grant + 1) mod N.
REQ-014 In IDLE, on finding a requester the block SHALL register its index into o_port and enter PASS on the next edge, giving one cycle of grant latency.
REQ-015 In PASS, o_tdata, o_tlast and o_tvalid SHALL combinationally equal the granted port's signals, that port's i_tready SHALL equal o_tready, and all other i_tready SHALL be 0; passthrough latency is zero.
REQ-016 In PASS, a handshake (o_tvalid & o_tready & o_tlast) SHALL set last_grant = o_port and return the state to IDLE.
REQ-017 Each packet SHALL be followed by at least one IDLE cycle, including when the same port requests again.
REQ-018 A write with set_stb = 1 and set_addr = BASE SHALL load enable_mask[N-1:0] from set_data[N-1:0].
REQ-019 The new enable mask SHALL take effect on the cycle after the write; arbitration in the write cycle SHALL use the old mask.
REQ-020 Disabling the granted port mid-packet SHALL NOT truncate the packet: it SHALL complete, and the port SHALL then be ineligible.
REQ-021 A disabled port's i_tready SHALL be 0 outside PASS-on-that-port.
REQ-022 With enable_mask = 0, or with no enabled requester, the block SHALL remain in IDLE indefinitely.
REQ-023 o_tvalid deassertion by the granted port mid-packet (bubble) SHALL be passed through without losing the grant.

Reset
REQ-024 While rst_n = 0 at a clk edge, the block SHALL set: state = IDLE, last_grant = N-1 (so port 0 has first priority), o_port = 0, enable_mask = all ones, and stat_cnt = 0.
REQ-025 During reset, o_tvalid and all i_tready SHALL be 0.
REQ-026 A reset asserted mid-packet SHALL abandon the packet with no tlast emitted; downstream recovery is the converter's responsibility.

Configuration
REQ-027 When macro CHDR_CONV_SCHED_STATS_EN is defined, each port SHALL have a 16-bit counter that increments on every tlast handshake of that port and wraps from 0xFFFF to 0.
REQ-028 When CHDR_CONV_SCHED_STATS_EN is defined, a write to BASE+1 SHALL clear all counters; a clear coinciding with an increment SHALL yield 0.
REQ-029 When CHDR_CONV_SCHED_STATS_EN is undefined, stat_cnt SHALL be constant 0, no counter logic SHALL exist, and writes to BASE+1 SHALL be ignored.

Verification
REQ-030 Single port: N=4, port 2 sends one 3-beat packet with o_tready = 1 -> o_tvalid rises 1 cycle after i_tvalid, o_port = 2, and the 3 beats appear unchanged with tlast on beat 3.
REQ-031 Round-robin: all 4 ports continuously send 2-beat packets after reset -> grant order 0,1,2,3,0,1,... with exactly one idle cycle between packets.
REQ-032 Backpressure: o_tready toggles 1,0,1,0 during a packet -> the granted i_tready mirrors o_tready, other i_tready stay 0, and no beat is duplicated or lost.
REQ-033 Mask: write 0x5 to BASE while port 1 is mid-packet -> port 1 finishes its packet, then only ports 0 and 2 are granted and i_tready[1] = 0.
REQ-034 Reset mid-packet: drop rst_n during beat 2 of a port 3 packet -> o_tvalid = 0 the next cycle and the first grant after reset goes to port 0.
REQ-035 Stats (macro defined): send 5 packets on port 1 -> stat_cnt[31:16] = 5; write BASE+1 -> all counters read 0.

Source files
------------

// File: rtl/chdr_conv_sched.sv
// ---------------------------------------------------------------------------
// chdr_conv_sched
//
// Packet-granular round-robin scheduler that shares one downstream CHDR
// converter between NUM_PORTS input streams. A port is granted only between
// packets and then passes its whole packet (through tlast) combinationally
// to the converter. Each packet is followed by at least one IDLE cycle.
//
// Optional feature macro: CHDR_CONV_SCHED_STATS_EN
//   defined   -> per-port 16-bit completed-packet counters on stat_cnt,
//                cleared by a settings write to BASE+1
//   undefined -> stat_cnt is tied to 0 and BASE+1 writes are ignored
//
// Parameters:
//   BASE       settings-bus address of the enable-mask register
//   NUM_PORTS  number of input streams (2..8)
//
// Ports:
//   clk, rst_n                     clock, synchronous active-low reset
//   set_stb/set_addr/set_data      settings bus (BASE: enable mask,
//                                  BASE+1: clear counters when stats built)
//   i_tdata/i_tlast/i_tvalid/      per-port CHDR inputs, port k on
//   i_tready                       bits [64k+63:64k] of i_tdata
//   o_tdata/o_tlast/o_tvalid/      stream to the shared converter
//   o_tready
//   o_port                         index of the granted port
//   stat_cnt                       per-port completed-packet counters
// ---------------------------------------------------------------------------
module chdr_conv_sched #(
    parameter int BASE      = 0,
    parameter int NUM_PORTS = 4,
    localparam int P        = (NUM_PORTS <= 2) ? 1 : $clog2(NUM_PORTS)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      set_stb,
    input  logic [7:0]                set_addr,
    input  logic [31:0]               set_data,
    input  logic [64*NUM_PORTS-1:0]   i_tdata,
    input  logic [NUM_PORTS-1:0]      i_tlast,
    input  logic [NUM_PORTS-1:0]      i_tvalid,
    output logic [NUM_PORTS-1:0]      i_tready,
    output logic [63:0]               o_tdata,
    output logic                      o_tlast,
    output logic                      o_tvalid,
    input  logic                      o_tready,
    output logic [P-1:0]              o_port,
    output logic [16*NUM_PORTS-1:0]   stat_cnt
);

    typedef enum logic {
        IDLE = 1'b0,
        PASS = 1'b1
    } state_t;

    localparam logic [7:0] ADDR_CTRL = 8'(BASE);

    state_t                 state_q, state_d;
    logic [P-1:0]           last_grant_q, last_grant_d;
    logic [P-1:0]           o_port_q, o_port_d;
    logic [NUM_PORTS-1:0]   enable_mask_q, enable_mask_d;

    logic                   mask_wr;
    logic                   req_found;
    logic [P-1:0]           req_idx;
    logic                   pkt_done;

    // Only the low NUM_PORTS bits of set_data carry the mask.
    logic unused_set_data;
    assign unused_set_data = ^set_data[31:NUM_PORTS];

    assign mask_wr  = set_stb && (set_addr == ADDR_CTRL);
    assign pkt_done = (state_q == PASS) && o_tvalid && o_tready && o_tlast;
    assign o_port   = o_port_q;

    // Round-robin search: first enabled requester at or after last_grant+1,
    // wrapping modulo NUM_PORTS (which need not be a power of two).
    always_comb begin : scan
        int cand;
        req_found = 1'b0;
        req_idx   = '0;
        cand      = 0;
        for (int i = 1; i <= NUM_PORTS; i++) begin
            cand = int'(last_grant_q) + i;
            if (cand >= NUM_PORTS) begin
                cand = cand - NUM_PORTS;
            end
            if (!req_found && enable_mask_q[cand] && i_tvalid[cand]) begin
                req_found = 1'b1;
                req_idx   = P'(cand);
            end
        end
    end

    // State register. The enable mask is written here too, so a write
    // only influences arbitration from the following cycle on.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            last_grant_q  <= P'(NUM_PORTS - 1);
            o_port_q      <= '0;
            enable_mask_q <= '1;
        end else begin
            state_q       <= state_d;
            last_grant_q  <= last_grant_d;
            o_port_q      <= o_port_d;
            enable_mask_q <= enable_mask_d;
        end
    end

    // Next-state logic. PASS ignores the mask on purpose: disabling the
    // granted port only makes it ineligible once its packet has finished.
    always_comb begin
        state_d       = state_q;
        last_grant_d  = last_grant_q;
        o_port_d      = o_port_q;
        enable_mask_d = enable_mask_q;
        if (mask_wr) begin
            enable_mask_d = set_data[NUM_PORTS-1:0];
        end
        case (state_q)
            IDLE: begin
                if (req_found) begin
                    o_port_d = req_idx;
                    state_d  = PASS;
                end
            end
            PASS: begin
                if (pkt_done) begin
                    last_grant_d = o_port_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic. Gating with rst_n keeps o_tvalid and i_tready low
    // throughout reset, even in the cycle reset is first asserted.
    always_comb begin
        o_tdata  = '0;
        o_tlast  = 1'b0;
        o_tvalid = 1'b0;
        i_tready = '0;
        if (rst_n && (state_q == PASS)) begin
            o_tdata            = i_tdata[64*int'(o_port_q) +: 64];
            o_tlast            = i_tlast[o_port_q];
            o_tvalid           = i_tvalid[o_port_q];
            i_tready[o_port_q] = o_tready;
        end
    end

`ifdef CHDR_CONV_SCHED_STATS_EN
    localparam logic [7:0] ADDR_CLR = 8'(BASE + 1);

    logic        clr_wr;
    logic [15:0] cnt_q [NUM_PORTS];
    logic [15:0] cnt_d [NUM_PORTS];

    assign clr_wr = set_stb && (set_addr == ADDR_CLR);

    // Counter next state: clear beats a coinciding increment; the
    // 16-bit add wraps naturally from 0xFFFF to 0.
    always_comb begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            cnt_d[k] = cnt_q[k];
            if (clr_wr) begin
                cnt_d[k] = '0;
            end else if (pkt_done && (o_port_q == P'(k))) begin
                cnt_d[k] = cnt_q[k] + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (!rst_n) begin
                cnt_q[k] <= '0;
            end else begin
                cnt_q[k] <= cnt_d[k];
            end
        end
    end

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_stat
        assign stat_cnt[16*g +: 16] = cnt_q[g];
    end
`else
    assign stat_cnt = '0;
`endif

endmodule
